// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM driving datapath selects and enables.
// Outputs depend only on the current state; each instruction takes 3-5 cycles from FETCH to FETCH.
// No flow control: the FSM advances on every clock; an active-low async reset returns it to FETCH.
module main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             ALUOp,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  // The state register is kept as raw bits so that encodings 11-15 remain
  // representable; they decode to the all-zero output set and return to FETCH.
  logic [3:0]       state_q;
  state_e           state_cur;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             retire;

  // Funct[4:1] carry no meaning for this controller.
  logic             unused_funct;
  assign unused_funct = ^Funct[4:1];

  assign state_cur  = state_e'(state_q);
  assign State      = state_q;
  assign InstrCount = cnt_q;

  // State register: reset forces FETCH immediately, aborting any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= 4'(S_FETCH);
    end else begin
      state_q <= 4'(state_d);
    end
  end

  // Next-state logic: Op/Funct are only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_cur)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode: a pure function of the current state, zero unless listed.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    Illegal   = 1'b0;
    case (state_cur)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        NextPC    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB   = 2'b01;
      end
      S_MEMRD: begin
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
      end
      S_EXECUTER: begin
        ALUOp     = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b1;
      end
      S_ALUWB: begin
        RegW      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      S_UNKNOWN: begin
        Illegal   = 1'b1;
      end
      default: begin
        Illegal   = 1'b0;
      end
    endcase
  end

  // An instruction retires on the edge leaving its final state; UNKNOWN does not count.
  always_comb begin
    retire = (state_cur == S_MEMWB) || (state_cur == S_MEMWR) ||
             (state_cur == S_ALUWB) || (state_cur == S_BRANCH);
    cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed instruction mix, mid-instruction reset, counter wrap,
// unused-encoding recovery, then randomized instructions against a per-instruction model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_main_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]    State;
  logic [CW-1:0] InstrCount;

  main_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .Illegal(Illegal), .State(State),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_model = 0;

  // Instruction kinds used by the model.
  localparam int K_LDR = 0, K_STR = 1, K_DPR = 2, K_DPI = 3, K_B = 4, K_UNK = 5;

  wire [13:0] obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                     NextPC, RegW, MemW, Branch, ALUOp, Illegal};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Output table: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp,Illegal}
  function automatic logic [13:0] exp_out(input int s);
    case (s)
      0:  return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b1, 5'b00000};
      1:  return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 5'b00000};
      2:  return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 5'b00000};
      3:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00000};
      4:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 5'b10000};
      5:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 5'b01000};
      6:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00010};
      7:  return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 5'b00010};
      8:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 5'b10000};
      9:  return {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 5'b00100};
      10: return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00001};
      default: return 14'd0;
    endcase
  endfunction

  // Runs one instruction of the given kind from FETCH. Stops (without stepping)
  // on reaching abort_at, leaving the caller at the falling edge in that state.
  task automatic run_instr(input int kind, input int abort_at, input logic [5:0] fixed_funct,
                           input bit use_fixed);
    int path[$];
    logic [1:0] op;
    logic [5:0] fn;
    fn = use_fixed ? fixed_funct : 6'($urandom);
    case (kind)
      K_LDR: begin op = 2'b01; fn[0] = 1'b1; path = '{0, 1, 2, 3, 4}; end
      K_STR: begin op = 2'b01; fn[0] = 1'b0; path = '{0, 1, 2, 5}; end
      K_DPR: begin op = 2'b00; fn[5] = 1'b0; path = '{0, 1, 6, 8}; end
      K_DPI: begin op = 2'b00; fn[5] = 1'b1; path = '{0, 1, 7, 8}; end
      K_B:   begin op = 2'b10;               path = '{0, 1, 9}; end
      default: begin op = 2'b11;             path = '{0, 1, 10}; end
    endcase
    foreach (path[i]) begin
      check_val($sformatf("state k%0d c%0d", kind, i), 32'(State), 32'(path[i]));
      check_val($sformatf("outs s%0d", path[i]), 32'(obs), 32'(exp_out(path[i])));
      check_val("count", 32'(InstrCount), 32'(cnt_model));
      if (path[i] == abort_at) return;
      if (path[i] == 1) begin
        Op = op; Funct = fn;
      end else if (path[i] == 2) begin
        Op = 2'($urandom); Funct = {5'($urandom), fn[0]};
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (kind != K_UNK) cnt_model = (cnt_model + 1) % (1 << CW);
  endtask

  initial begin
    reset = 1'b0;
    Op    = 2'b00;
    Funct = 6'd0;
    #12;
    check_val("rst state", 32'(State), 32'd0);
    check_val("rst count", 32'(InstrCount), 32'd0);
    check_val("rst outs", 32'(obs), 32'(exp_out(0)));
    @(negedge clk);
    reset = 1'b1;

    // Directed mix: LDR with literal funct, STR, both ALU forms, branch, unknown.
    run_instr(K_LDR, -1, 6'b011001, 1'b1);
    run_instr(K_STR, -1, 6'b011000, 1'b1);
    run_instr(K_DPR, -1, 6'd0, 1'b0);
    run_instr(K_DPI, -1, 6'd0, 1'b0);
    run_instr(K_B,   -1, 6'd0, 1'b0);
    run_instr(K_UNK, -1, 6'd0, 1'b0);
    check_val("count after mix", 32'(InstrCount), 32'd5);

    // Asynchronous reset while in MEMRD: effect visible before the next edge.
    run_instr(K_LDR, 3, 6'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_val("async rst state", 32'(State), 32'd0);
    check_val("async rst count", 32'(InstrCount), 32'd0);
    check_val("async rst outs", 32'(obs), 32'(exp_out(0)));
    cnt_model = 0;
    @(posedge clk);
    #1;
    check_val("held rst state", 32'(State), 32'd0);
    check_val("held rst regw", 32'(RegW), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Sixteen ALU instructions wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_instr(($urandom & 1) ? K_DPI : K_DPR, -1, 6'd0, 1'b0);
    check_val("wrap", 32'(InstrCount), 32'd0);

    // Unused encoding 12: all outputs zero, next state FETCH, no count.
    force dut.state_q = 4'd12;
    #1;
    check_val("unused state", 32'(State), 32'd12);
    check_val("unused outs", 32'(obs), 32'd0);
    check_val("unused next", 32'(dut.state_d), 32'd0);
    @(posedge clk);
    #1;
    check_val("unused count", 32'(InstrCount), 32'(cnt_model));
    release dut.state_q;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cnt_model = 0;

    // Randomized instruction stream, including garbage on Op/Funct outside sampling states.
    for (int i = 0; i < 80; i++) run_instr(int'($urandom_range(0, 5)), -1, 6'd0, 1'b0);
    check_val("final count", 32'(InstrCount), 32'(cnt_model));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: Op  in  2  instruction opcode field Instr[27:26].
REQ-005 Port: Funct  in  6  instruction function field Instr[25:20]; bit 5 = I (immediate), bit 0 = L/S.
REQ-006 Port: IRWrite  out  1  instruction register load enable.
REQ-007 Port: AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
REQ-008 Port: ALUSrcA  out  2  SrcA select: 00 = register A, 01 = PC.
REQ-009 Port: ALUSrcB  out  2  SrcB select: 00 = register WriteData, 01 = ExtImm, 10 = constant 4.
REQ-010 Port: ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 Port: NextPC, RegW, MemW, Branch, ALUOp  out  1 each  PC update request, register write, memory write, branch request, ALU decoder enable.
REQ-012 Port: Illegal  out  1  one-cycle pulse for an unsupported opcode.
REQ-013 Port: State  out  4  current state encoding, for debug.
REQ-014 Port: InstrCount  out  CNT_W  count of retired instructions.

Function
REQ-015 Moore FSM: every control output SHALL be a pure function of the current state, with no combinational path from Op or Funct.
REQ-016 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
REQ-017 Defaults: any output not listed for a state SHALL be 0.
REQ-018 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1; next state is DECODE.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; next state by Op:
  - Op=01 -> MEMADR
  - Op=00 with Funct[5]=1 -> EXECUTEI
  - Op=00 with Funct[5]=0 -> EXECUTER
  - Op=10 -> BRANCH
  - Op=11 -> UNKNOWN
REQ-020 MEMADR: ALUSrcA=00, ALUSrcB=01; next state is MEMRD if Funct[0]=1, else MEMWR.
REQ-021 MEMRD: AdrSrc=1, ResultSrc=00; next state is MEMWB.
REQ-022 MEMWB: ResultSrc=01, RegW=1; next state is FETCH.
REQ-023 MEMWR: AdrSrc=1, ResultSrc=00, MemW=1; next state is FETCH.
REQ-024 EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1; next state is ALUWB.
REQ-025 EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1; next state is ALUWB.
REQ-026 ALUWB: ResultSrc=00, RegW=1; next state is FETCH.
REQ-027 BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1; next state is FETCH.
REQ-028 UNKNOWN: all control outputs 0 except Illegal=1; next state is FETCH.
REQ-029 Unused encodings 11-15: all outputs 0, Illegal=0; next state is FETCH.
REQ-030 Op and Funct SHALL be sampled only in DECODE and MEMADR, and ignored in all other states.
REQ-031 Instruction latency from FETCH to FETCH:
  - LDR: 5 cycles
  - STR: 4 cycles
  - data-processing: 4 cycles
  - branch: 3 cycles
  - unknown opcode: 3 cycles
REQ-032 InstrCount SHALL increment by 1 on each clock edge that leaves MEMWB, MEMWR, ALUWB or BRANCH; it SHALL NOT increment on leaving UNKNOWN or an unused encoding.
REQ-033 InstrCount SHALL wrap from 2^CNT_W-1 to 0 without any flag.

Reset
REQ-034 While reset=0: state SHALL be FETCH, InstrCount SHALL be 0, and outputs SHALL equal the FETCH decode, independent of clk.
REQ-035 Reset asserted mid-instruction SHALL abort that instruction immediately; no further RegW or MemW pulse from it, and it is not counted.
REQ-036 The first rising clk edge after reset deasserts SHALL move the FSM from FETCH to DECODE.

Verification
REQ-037 Reset, then Op=01 with Funct=011001 (LDR imm) -> states 0,1,2,3,4,0; RegW=1 only in state 4; ResultSrc=01 in state 4; InstrCount=1.
REQ-038 Op=01 with Funct=011000 (STR) -> states 0,1,2,5,0; MemW=1 for exactly one cycle with AdrSrc=1; InstrCount +1.
REQ-039 Op=00 with Funct[5]=0, then Funct[5]=1 -> path through state 6 then state 7, each followed by 8; ALUOp=1 only in states 6 and 7; InstrCount +2.
REQ-040 Op=10 -> states 0,1,9,0; Branch=1 for one cycle, ALUSrcB=01; then Op=11 -> Illegal pulse in state 10 and InstrCount unchanged.
REQ-041 Drive reset=0 asynchronously during state 3 -> State=0 and InstrCount=0 before the next clk edge; no RegW pulse follows.
REQ-042 With CNT_W=4, run 16 ALU instructions -> InstrCount wraps to 0; force state 12 via the debug path -> next state 0, all outputs 0.
